// File: rtl/adder_pkg.sv
// Shared definitions for the chunk-serial adder: controller states and the
// chunk-count helper used to size the datapath.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out; the serial adder reuses
// one instance on every RUN cycle.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunk_serial_adder.sv
// Adds/subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// publishing sum/cout/ovf together only when the last chunk completes.
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import adder_pkg::*;

  localparam int N  = chunk_count(WIDTH, CHUNK);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunk_serial_adder: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_chunk_cout)
  );

  // Partial result with the current chunk merged in; becomes sum on the last chunk.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) w_acc_next[k*CHUNK +: CHUNK] = w_chunk_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b ^ {WIDTH{sub}};
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_carry <= w_chunk_cout;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_chunk_cout;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: default 32/8 instance plus a 16/16
// (single-chunk) instance sharing clock and reset.
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  logic        s_start = 1'b0;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_cin = 1'b0, s_sub = 1'b0;
  logic        s_busy, s_done, s_cout, s_ovf;
  logic [15:0] s_sum;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  always #5 clk = ~clk;

  chunk_serial_adder u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
    .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  // Present operands for one accepting edge, then scramble inputs while busy.
  task automatic start_op(input logic [31:0] ta, tb, input logic tcin, tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b1; sub = 1'b1;
  endtask

  // Negedges after the accepting edge until done is seen; -1 if never.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, cout, ovf, sum} !== 36'd0) begin
      errors++;
      $display("FAIL reset_w32: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    checks++;
    if ({s_busy, s_done, s_cout, s_ovf, s_sum} !== 20'd0) begin
      errors++;
      $display("FAIL reset_w16: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               s_busy, s_done, s_sum, s_cout, s_ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults;
    int cyc;
    start_op(32'hF0000000, 32'h00000007, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL default_busy: busy=%b, required 1", busy);
    end
    checks++;
    if (sum !== 32'h0) begin
      errors++; $display("FAIL default_no_partial: sum=%h, required 00000000", sum);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 4) begin
      errors++; $display("FAIL default_latency: done after %0d cycles, required 4", cyc);
    end
    checks++;
    if ({sum, cout, ovf} !== {32'hF0000007, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL default_result: sum=%h cout=%b ovf=%b, required F0000007 0 0", sum, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL done_to_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    checks++;
    if (sum !== 32'hF0000007) begin
      errors++; $display("FAIL result_hold: sum=%h, required F0000007", sum);
    end
  endtask

  task automatic test_add;
    vec_t v[4];
    int   cyc;
    v[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    v[1] = '{32'hF000F000, 32'h0AA00007, 1'b1, 1'b0, 32'hFAA0F008, 1'b0, 1'b0};
    v[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v[3] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      start_op(v[i].a, v[i].b, v[i].cin, v[i].sub);
      wait_done(cyc);
      checks++;
      if (cyc !== 4) begin
        errors++; $display("FAIL add%0d_latency: %0d cycles, required 4", i, cyc);
      end
      checks++;
      if ({sum, cout, ovf} !== {v[i].s, v[i].co, v[i].ov}) begin
        errors++;
        $display("FAIL add%0d_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                 i, sum, cout, ovf, v[i].s, v[i].co, v[i].ov);
      end
    end
  endtask

  task automatic test_sub;
    vec_t v[4];
    int   cyc;
    v[0] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[1] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    v[2] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
    v[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_op(v[i].a, v[i].b, v[i].cin, v[i].sub);
      wait_done(cyc);
      checks++;
      if (cyc !== 4) begin
        errors++; $display("FAIL sub%0d_latency: %0d cycles, required 4", i, cyc);
      end
      checks++;
      if ({sum, cout, ovf} !== {v[i].s, v[i].co, v[i].ov}) begin
        errors++;
        $display("FAIL sub%0d_result: sum=%h cout=%b ovf=%b, required %h %b %b",
                 i, sum, cout, ovf, v[i].s, v[i].co, v[i].ov);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000001;
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || sum !== 32'h23456789) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d sum=%h, required 4 23456789", cyc, sum);
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum !== 32'h23456789) begin
        errors++;
        $display("FAIL b2b_hold%0d: done=%b sum=%h, required 0 23456789", j, done, sum);
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, sum, cout, ovf} !== {1'b1, 32'h00010000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: done=%b sum=%h cout=%b ovf=%b, required 1 00010000 0 0",
               done, sum, cout, ovf);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int pulses;
    start_op(32'hF0000000, 32'h00000007, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, cout, ovf, sum} !== 36'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_no_done: %0d active cycles, required 0", pulses);
    end
    start_op(32'h00000001, 32'h00000001, 1'b0, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || {sum, cout, ovf} !== {32'h00000002, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_recover: cycles=%0d sum=%h cout=%b ovf=%b, required 4 00000002 0 0",
               cyc, sum, cout, ovf);
    end
  endtask

  task automatic test_single_chunk;
    @(negedge clk);
    s_a = 16'hF000; s_b = 16'h0007; s_cin = 1'b0; s_sub = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_a = 16'hBEEF; s_b = 16'hF00D;
    checks++;
    if ({s_busy, s_done} !== 2'b10) begin
      errors++; $display("FAIL n1_run: busy=%b done=%b, required 1 0", s_busy, s_done);
    end
    @(negedge clk);
    checks++;
    if ({s_done, s_sum, s_cout, s_ovf} !== {1'b1, 16'hF007, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL n1_done: done=%b sum=%h cout=%b ovf=%b, required 1 F007 0 0",
               s_done, s_sum, s_cout, s_ovf);
    end
    @(negedge clk);
    checks++;
    if ({s_busy, s_done} !== 2'b00) begin
      errors++; $display("FAIL n1_idle: busy=%b done=%b, required 0 0", s_busy, s_done);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_single_chunk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
